// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if
//   Bundles the fetch-stage, data-stage and physical-memory signals that the
//   arbiter sits between.
//   slave  : arbiter view (requests and Mem_ReadData in; grants, data,
//            Mem_* strobes and Stall out).
//   master : pipeline/memory/testbench view (the mirror image).
interface memory_port_arbiter_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 20
);
  // fetch stage
  logic                  IF_Req;
  logic [ADDR_WIDTH-1:0] IF_Address;
  logic                  IF_Grant;
  logic                  IF_DataValid;
  logic [DATA_WIDTH-1:0] IF_Data;
  // data stage
  logic                  MEM_Req;
  logic                  MEM_WriteEnable;
  logic [ADDR_WIDTH-1:0] MEM_Address;
  logic [DATA_WIDTH-1:0] MEM_WriteData;
  logic                  MEM_Grant;
  logic                  MEM_DataValid;
  logic [DATA_WIDTH-1:0] MEM_Data;
  // physical memory port
  logic [ADDR_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0] Mem_WriteData;
  logic                  Mem_WriteEnable;
  logic                  Mem_ReadEnable;
  logic [DATA_WIDTH-1:0] Mem_ReadData;
  // pipeline control
  logic                  Stall;

  modport slave (
    input  IF_Req, IF_Address,
    input  MEM_Req, MEM_WriteEnable, MEM_Address, MEM_WriteData,
    input  Mem_ReadData,
    output IF_Grant, IF_DataValid, IF_Data,
    output MEM_Grant, MEM_DataValid, MEM_Data,
    output Mem_Address, Mem_WriteData, Mem_WriteEnable, Mem_ReadEnable,
    output Stall
  );

  modport master (
    output IF_Req, IF_Address,
    output MEM_Req, MEM_WriteEnable, MEM_Address, MEM_WriteData,
    output Mem_ReadData,
    input  IF_Grant, IF_DataValid, IF_Data,
    input  MEM_Grant, MEM_DataValid, MEM_Data,
    input  Mem_Address, Mem_WriteData, Mem_WriteEnable, Mem_ReadEnable,
    input  Stall
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//   Shares one single-port fixed-latency memory between the IF and MEM
//   pipeline stages. MEM has priority, except that IF is forced through once
//   it has watched STARVE_LIMIT consecutive MEM grants. Reads park the
//   arbiter in WAIT for MEM_LATENCY cycles; writes finish in the issue cycle.
// Ports:
//   Clock, Reset : clock, synchronous active-high reset
//   bus          : memory_port_arbiter_if.slave (requests, grants, returned
//                  data, physical memory port, Stall)
module memory_port_arbiter #(
  parameter int DATA_WIDTH   = 20,
  parameter int ADDR_WIDTH   = 20,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  memory_port_arbiter_if.slave  bus
);
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [3:0]            r_starve;
  logic                  r_owner;      // 1 = MEM owns the in-flight read
  logic [DATA_WIDTH-1:0] r_if_data;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_if_vld;
  logic                  r_mem_vld;

  logic w_idle, w_if_grant, w_mem_grant, w_read;

  // Grants are only possible in IDLE and never while Reset is asserted.
  assign w_idle      = (r_state == IDLE) & ~Reset;
  assign w_if_grant  = w_idle & bus.IF_Req & (~bus.MEM_Req | (r_starve == LIM));
  assign w_mem_grant = w_idle & bus.MEM_Req & ~w_if_grant;
  assign w_read      = w_if_grant | (w_mem_grant & ~bus.MEM_WriteEnable);

  assign bus.IF_Grant      = w_if_grant;
  assign bus.MEM_Grant     = w_mem_grant;
  assign bus.IF_Data       = r_if_data;
  assign bus.MEM_Data      = r_mem_data;
  assign bus.IF_DataValid  = r_if_vld;
  assign bus.MEM_DataValid = r_mem_vld;
  assign bus.Stall         = (r_state == WAIT)
                           | (bus.IF_Req  & ~w_if_grant)
                           | (bus.MEM_Req & ~w_mem_grant);

  // Physical port is driven only in a grant cycle; otherwise all zero.
  always_comb begin
    bus.Mem_Address     = '0;
    bus.Mem_WriteData   = '0;
    bus.Mem_WriteEnable = 1'b0;
    bus.Mem_ReadEnable  = 1'b0;
    if (w_if_grant) begin
      bus.Mem_Address    = bus.IF_Address;
      bus.Mem_ReadEnable = 1'b1;
    end else if (w_mem_grant) begin
      bus.Mem_Address     = bus.MEM_Address;
      bus.Mem_WriteData   = bus.MEM_WriteData;
      bus.Mem_WriteEnable = bus.MEM_WriteEnable;
      bus.Mem_ReadEnable  = ~bus.MEM_WriteEnable;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_owner    <= 1'b0;
      r_if_data  <= '0;
      r_mem_data <= '0;
      r_if_vld   <= 1'b0;
      r_mem_vld  <= 1'b0;
    end else begin
      r_if_vld  <= 1'b0;
      r_mem_vld <= 1'b0;
      case (r_state)
        IDLE: if (w_read) begin
          r_state <= WAIT;
          r_cnt   <= LAT;
          r_owner <= w_mem_grant;
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // Count of 1 marks the cycle Mem_ReadData is valid.
          if (r_cnt == 4'd1) begin
            r_state <= IDLE;
            if (r_owner) begin
              r_mem_data <= bus.Mem_ReadData;
              r_mem_vld  <= 1'b1;
            end else begin
              r_if_data <= bus.Mem_ReadData;
              r_if_vld  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // Starvation counter only runs while IF is actually waiting.
      if (!bus.IF_Req || w_if_grant)
        r_starve <= '0;
      else if (w_mem_grant && (r_starve != LIM))
        r_starve <= r_starve + 4'd1;
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;
  localparam int DW  = 20;
  localparam int AW  = 20;
  localparam int LAT = 2;
  localparam int LIM = 3;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  memory_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memory_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // {IF_Grant, MEM_Grant, Mem_ReadEnable, Mem_WriteEnable, Stall}
  function automatic logic [4:0] ctl();
    return {bus.IF_Grant, bus.MEM_Grant, bus.Mem_ReadEnable, bus.Mem_WriteEnable, bus.Stall};
  endfunction

  function automatic logic [1:0] vld();
    return {bus.IF_DataValid, bus.MEM_DataValid};
  endfunction

  task automatic set_in(input logic ir, input logic [AW-1:0] ia, input logic mr,
                        input logic we, input logic [AW-1:0] ma, input logic [DW-1:0] wd);
    bus.IF_Req          = ir;
    bus.IF_Address      = ia;
    bus.MEM_Req         = mr;
    bus.MEM_WriteEnable = we;
    bus.MEM_Address     = ma;
    bus.MEM_WriteData   = wd;
  endtask

  task automatic next_cyc();
    @(posedge Clock); #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
    bus.Mem_ReadData = '0;
    Reset = 1'b1;
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  typedef struct {
    logic          ifr, memr, we;
    logic [4:0]    ctl;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } vec_t;

  typedef struct {
    int            due;
    logic          own;   // 1 = MEM
    logic [DW-1:0] w;
  } rd_t;

  initial begin
    vec_t          vt[6];
    rd_t           pend[$];
    int            free_at, starve;
    logic          ir, mr, mwe, gi, gm, busy, stall, ev_if, ev_mem;
    logic [AW-1:0] ia, ma, e_addr;
    logic [DW-1:0] md, e_ifd, e_memd, e_wd, rdata;

    // ---------------- reset state ----------------
    do_reset();
    @(negedge Clock);
    chk("reset_ctl",  ctl(), 5'b0);
    chk("reset_vld",  vld(), 2'b0);
    chk("reset_ifd",  bus.IF_Data, 0);
    chk("reset_memd", bus.MEM_Data, 0);
    chk("reset_addr", bus.Mem_Address, 0);

    // ---------------- single-cycle arbitration table ----------------
    // IF addr 0x11111, MEM addr 0x22222, MEM wdata 0x33333
    vt[0] = '{1'b0, 1'b0, 1'b0, 5'b00000, 20'h00000, 20'h00000};
    vt[1] = '{1'b1, 1'b0, 1'b0, 5'b10100, 20'h11111, 20'h00000};
    vt[2] = '{1'b0, 1'b1, 1'b0, 5'b01100, 20'h22222, 20'h33333};
    vt[3] = '{1'b0, 1'b1, 1'b1, 5'b01010, 20'h22222, 20'h33333};
    vt[4] = '{1'b1, 1'b1, 1'b0, 5'b01101, 20'h22222, 20'h33333};
    vt[5] = '{1'b1, 1'b1, 1'b1, 5'b01011, 20'h22222, 20'h33333};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      set_in(vt[i].ifr, 20'h11111, vt[i].memr, vt[i].we, 20'h22222, 20'h33333);
      @(negedge Clock);
      chk($sformatf("vec%0d_ctl", i),  ctl(), vt[i].ctl);
      chk($sformatf("vec%0d_addr", i), bus.Mem_Address, vt[i].addr);
      chk($sformatf("vec%0d_wd", i),   bus.Mem_WriteData, vt[i].wd);
    end

    // ---------------- IF read, latency 2 ----------------
    do_reset();
    set_in(1'b1, 20'h00010, 1'b0, 1'b0, '0, '0);
    @(negedge Clock);
    chk("ifrd_c0_ctl",  ctl(), 5'b10100);
    chk("ifrd_c0_addr", bus.Mem_Address, 20'h00010);
    next_cyc(); bus.IF_Req = 1'b0;
    @(negedge Clock); chk("ifrd_c1_ctl", ctl(), 5'b00001);
    next_cyc(); bus.Mem_ReadData = 20'hABCDE;
    @(negedge Clock); chk("ifrd_c2_ctl", ctl(), 5'b00001);
    next_cyc(); bus.Mem_ReadData = 20'h0;
    @(negedge Clock);
    chk("ifrd_c3_ctl", ctl(), 5'b00000);
    chk("ifrd_c3_vld", vld(), 2'b10);
    chk("ifrd_c3_ifd", bus.IF_Data, 20'hABCDE);
    next_cyc();
    @(negedge Clock);
    chk("ifrd_c4_vld", vld(), 2'b00);
    chk("ifrd_c4_ifd", bus.IF_Data, 20'hABCDE);

    // ---------------- back-to-back writes ----------------
    do_reset();
    set_in(1'b0, '0, 1'b1, 1'b1, 20'h00200, 20'h12345);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk($sformatf("wr%0d_ctl", i),  ctl(), 5'b01010);
      chk($sformatf("wr%0d_addr", i), bus.Mem_Address, 20'h00200);
      chk($sformatf("wr%0d_wd", i),   bus.Mem_WriteData, 20'h12345);
      chk($sformatf("wr%0d_vld", i),  vld(), 2'b00);
      next_cyc();
    end
    bus.MEM_Req = 1'b0;
    @(negedge Clock);
    chk("wr_after_vld", vld(), 2'b00);

    // ---------------- simultaneous IF + MEM read ----------------
    do_reset();
    set_in(1'b1, 20'h00040, 1'b1, 1'b0, 20'h00080, '0);
    @(negedge Clock);
    chk("both_c0_ctl",  ctl(), 5'b01101);
    chk("both_c0_addr", bus.Mem_Address, 20'h00080);
    next_cyc(); bus.MEM_Req = 1'b0;
    @(negedge Clock); chk("both_c1_ctl", ctl(), 5'b00001);
    next_cyc(); bus.Mem_ReadData = 20'h55555;
    @(negedge Clock); chk("both_c2_ctl", ctl(), 5'b00001);
    next_cyc(); bus.Mem_ReadData = 20'h0;
    @(negedge Clock);
    chk("both_c3_ctl",  ctl(), 5'b10100);
    chk("both_c3_addr", bus.Mem_Address, 20'h00040);
    chk("both_c3_vld",  vld(), 2'b01);
    chk("both_c3_memd", bus.MEM_Data, 20'h55555);
    chk("both_c3_ifd",  bus.IF_Data, 20'h0);
    next_cyc(); bus.IF_Req = 1'b0;
    next_cyc(); bus.Mem_ReadData = 20'h66666;
    next_cyc(); bus.Mem_ReadData = 20'h0;
    @(negedge Clock);
    chk("both_c6_vld",  vld(), 2'b10);
    chk("both_c6_ifd",  bus.IF_Data, 20'h66666);
    chk("both_c6_memd", bus.MEM_Data, 20'h55555);

    // ---------------- starvation override ----------------
    do_reset();
    set_in(1'b1, 20'h00007, 1'b1, 1'b1, 20'h00300, 20'h00abc);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk($sformatf("starve%0d_ctl", i), ctl(), 5'b01011);
      next_cyc();
    end
    @(negedge Clock);
    chk("starve3_ctl",  ctl(), 5'b10101);
    chk("starve3_addr", bus.Mem_Address, 20'h00007);
    next_cyc();  // IF re-requests, MEM still waiting: both sit out WAIT
    next_cyc();
    next_cyc();
    @(negedge Clock);
    chk("starve_cleared_ctl", ctl(), 5'b01011);
    next_cyc();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // ---------------- reset in the middle of WAIT ----------------
    do_reset();
    set_in(1'b1, 20'h00010, 1'b0, 1'b0, '0, '0);
    next_cyc(); bus.IF_Req = 1'b0; Reset = 1'b1;
    next_cyc(); bus.IF_Req = 1'b1; bus.MEM_Req = 1'b1; bus.Mem_ReadData = 20'h77777;
    @(negedge Clock);
    chk("rstw_c2_grants", ctl() >> 1, 4'b0000);
    chk("rstw_c2_vld",    vld(), 2'b00);
    chk("rstw_c2_ifd",    bus.IF_Data, 20'h0);
    next_cyc(); Reset = 1'b0; set_in(1'b0, '0, 1'b0, 1'b0, '0, '0); bus.Mem_ReadData = 20'h0;
    @(negedge Clock);
    chk("rstw_c3_ctl", ctl(), 5'b00000);
    chk("rstw_c3_vld", vld(), 2'b00);
    chk("rstw_c3_ifd", bus.IF_Data, 20'h0);

    // ---------------- requests during WAIT ----------------
    do_reset();
    set_in(1'b1, 20'h00020, 1'b0, 1'b0, '0, '0);
    next_cyc(); set_in(1'b0, '0, 1'b1, 1'b1, 20'h00400, 20'h00001);
    @(negedge Clock); chk("wwait_c1_ctl", ctl(), 5'b00001);
    next_cyc(); bus.Mem_ReadData = 20'h01234;
    @(negedge Clock); chk("wwait_c2_ctl", ctl(), 5'b00001);
    next_cyc(); bus.Mem_ReadData = 20'h0;
    @(negedge Clock);
    chk("wwait_c3_ctl", ctl(), 5'b01010);
    chk("wwait_c3_vld", vld(), 2'b10);
    chk("wwait_c3_ifd", bus.IF_Data, 20'h01234);
    next_cyc(); bus.MEM_Req = 1'b0;

    // ---------------- randomized run vs. transaction model ----------------
    // Model: the port is busy until cycle free_at; a read issued at cycle T
    // returns its word at T+LAT and shows up as DataValid at T+LAT+1.
    do_reset();
    free_at = 0; starve = 0;
    ir = 1'b0; mr = 1'b0; mwe = 1'b0;
    ia = '0; ma = '0; md = '0;
    e_ifd = '0; e_memd = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!ir && $urandom_range(0, 2) == 0) begin ir = 1'b1; ia = AW'($urandom); end
      if (!mr && $urandom_range(0, 2) == 0) begin
        mr = 1'b1; mwe = 1'($urandom); ma = AW'($urandom); md = DW'($urandom);
      end
      set_in(ir, ia, mr, mwe, ma, md);

      ev_if = 1'b0; ev_mem = 1'b0;
      if (pend.size() > 0 && pend[0].due == c - 1) begin
        if (pend[0].own) begin ev_mem = 1'b1; e_memd = pend[0].w; end
        else             begin ev_if  = 1'b1; e_ifd  = pend[0].w; end
        void'(pend.pop_front());
      end
      rdata = DW'($urandom);
      if (pend.size() > 0 && pend[0].due == c) rdata = pend[0].w;
      bus.Mem_ReadData = rdata;

      busy  = (c < free_at);
      gi    = !busy && ir && (!mr || starve == LIM);
      gm    = !busy && mr && !gi;
      stall = busy || (ir && !gi) || (mr && !gm);
      if (gi || (gm && !mwe)) begin
        pend.push_back('{c + LAT, gm, DW'($urandom)});
        free_at = c + LAT + 1;
      end
      e_addr = gi ? ia : (gm ? ma : '0);
      e_wd   = gm ? md : '0;

      @(negedge Clock);
      chk("rnd_ctl",  ctl(), {gi, gm, gi || (gm && !mwe), gm && mwe, stall});
      chk("rnd_addr", bus.Mem_Address, e_addr);
      chk("rnd_wd",   bus.Mem_WriteData, e_wd);
      chk("rnd_vld",  vld(), {ev_if, ev_mem});
      chk("rnd_ifd",  bus.IF_Data, e_ifd);
      chk("rnd_memd", bus.MEM_Data, e_memd);

      if (!ir || gi)                starve = 0;
      else if (gm && starve < LIM)  starve++;
      if (gi) ir = 1'b0;
      if (gm) mr = 1'b0;
      next_cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Arbiter and sequencer that lets the pipeline's instruction-fetch stage and memory-access stage share one single-port, fixed-latency memory. It grants one requester per transaction and drives the physical memory port. It registers returned read data per requester and raises a pipeline stall while any request is pending or a read is in flight. It sits between the IF/MEM stage outputs of the 5-stage 20-bit pipeline and the unified memory.

## Interface
Parameters:
- DATA_WIDTH, 20, memory word width.
- ADDR_WIDTH, 20, memory address width.
- MEM_LATENCY, 2, cycles from read issue to Mem_ReadData valid; legal range 1..15.
- STARVE_LIMIT, 3, consecutive MEM-stage grants allowed while IF is waiting before IF is forced; legal range 1..15.

Ports (clock and reset first):
- Clock, in, 1, single clock; all state updates on rising edge.
- Reset, in, 1, synchronous, active-high.
- IF_Req, in, 1, fetch read request; held until IF_Grant.
- IF_Address, in, ADDR_WIDTH, fetch address; stable while IF_Req is high.
- IF_Grant, out, 1, one-cycle pulse marking the issue cycle of the fetch read.
- IF_DataValid, out, 1, one-cycle pulse when IF_Data is updated.
- IF_Data, out, DATA_WIDTH, last fetched word, held between reads.
- MEM_Req, in, 1, data-stage request; held until MEM_Grant.
- MEM_WriteEnable, in, 1, 1 = write, 0 = read.
- MEM_Address, in, ADDR_WIDTH, data address.
- MEM_WriteData, in, DATA_WIDTH, write data.
- MEM_Grant, out, 1, one-cycle pulse marking the issue cycle of the data-stage transaction.
- MEM_DataValid, out, 1, one-cycle pulse when MEM_Data is updated; never asserted for writes.
- MEM_Data, out, DATA_WIDTH, last data-stage read word, held between reads.
- Mem_Address, out, ADDR_WIDTH, physical memory address.
- Mem_WriteData, out, DATA_WIDTH, physical write data.
- Mem_WriteEnable, out, 1, physical write strobe.
- Mem_ReadEnable, out, 1, physical read strobe.
- Mem_ReadData, in, DATA_WIDTH, physical read data, valid MEM_LATENCY cycles after the read strobe.
- Stall, out, 1, pipeline freeze request.

## Operation
- States: IDLE and WAIT. A 4-bit latency counter and a 1-bit owner flag (IF or MEM) track the in-flight read.
- Arbitration in IDLE (combinational on the current requests):
  - MEM has priority over IF.
  - Exception: IF wins when IF_Req = 1 and StarveCount = STARVE_LIMIT.
- Grant effects:
  - The granted requester's address, write data and write enable are routed to the Mem_* outputs in the same cycle.
  - Exactly one of Mem_ReadEnable or Mem_WriteEnable is high for that one cycle.
  - With no grant, all Mem_* outputs are 0.
- Write grant (MEM only): completes in the issue cycle; the state stays IDLE.
- Read grant: the state goes to WAIT, the counter loads MEM_LATENCY, and the owner is recorded.
- WAIT:
  - The counter decrements each cycle. When it reaches 1, Mem_ReadData is captured into the owner's data register.
  - In the next cycle the state returns to IDLE and the owner's DataValid pulses.
  - Requests are ignored in WAIT (no grants).
- StarveCount:
  - Increments, saturating at STARVE_LIMIT, on each MEM_Grant while IF_Req = 1.
  - Clears on IF_Grant, or in any cycle where IF_Req = 0.
- Stall = (state = WAIT) | (IF_Req & ~IF_Grant) | (MEM_Req & ~MEM_Grant).
- Requester rules:
  - Inputs are held stable while Req is high.
  - After a Grant, the requester may drop Req or present a new request in the next cycle.
- Reset (any state, including mid-WAIT):
  - Next state is IDLE, counter and StarveCount are 0, and any in-flight read is discarded.
  - IF_Data and MEM_Data are 0, and both DataValid outputs are 0.
  - While Reset is high, all Grants and Mem_* strobes are 0.

## Timing
- Read issued in cycle T: Grant and Mem_ReadEnable are high in T, and Mem_ReadData is sampled at the end of T+MEM_LATENCY.
- DataValid is high in T+MEM_LATENCY+1. The next grant may occur in that same cycle, so back-to-back reads occur every MEM_LATENCY+1 cycles.
- Writes have zero wait. Back-to-back writes are granted on consecutive cycles.
- Simultaneous IF_Req and MEM_Req in IDLE: MEM is granted; IF stays pending, and Stall stays high, until its turn.
- Data registers are updated only by their own owner's reads. The other port's data and valid are unaffected.
- Reset values of every output: all 0.

## Test plan
- Reset; IF_Req = 1, IF_Address = 0x00010 → IF_Grant and Mem_ReadEnable high in cycle 0 with Mem_Address = 0x00010. With Mem_ReadData = 0xABCDE at cycle 2, IF_DataValid is high and IF_Data = 0xABCDE in cycle 3. Stall is high in cycles 1–2 and low in cycle 3 if no new request is pending.
- MEM write to 0x00200 with data 0x12345, repeated for 3 consecutive cycles → MEM_Grant and Mem_WriteEnable high every cycle, Stall low, MEM_DataValid never high.
- IF_Req and a MEM read asserted together → MEM is granted first. IF_Grant follows in cycle 3 (MEM_LATENCY = 2). MEM_Data gets the first word; IF_Data is unchanged until its own read completes.
- IF_Req held high with 4 consecutive MEM writes requested → the first 3 cycles grant MEM, the 4th cycle grants IF, and StarveCount returns to 0.
- Reset asserted in cycle 1 of a WAIT → cycle 2 is IDLE with all outputs 0. Mem_ReadData presented afterwards produces no DataValid.
- Requests asserted during WAIT → no grants until return to IDLE; MEM is granted in the DataValid cycle.
